// File: rtl/parser_head_gen.sv
// Cuts the first HEAD_SLICES beats of each packet into tagged head slices, emits one tagged
// meta slice per packet, and forwards accepted beats through a single payload register.
//
// state | meaning
// IDLE  | waiting for SOP; non-SOP beats are dropped as errors
// HEAD  | emitting head slices for the open packet
// DRAIN | head complete; remaining beats go to the payload path only
// DROP  | discarding a packet that started inside another one
module parser_head_gen #(
  parameter int DATA_WIDTH  = 256,
  parameter int HEAD_SLICES = 4,
  parameter int META_WIDTH  = 128,
  parameter int OFF_W       = 5,
  parameter int TAG_WIDTH   = OFF_W + 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_sop,
  input  logic                             i_eop,
  input  logic [OFF_W-1:0]                 i_empty,
  input  logic [7:0]                       i_port,
  input  logic [15:0]                      i_pkt_len,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta,
  output logic                             o_pkt_valid,
  input  logic                             i_pkt_ready,
  output logic [DATA_WIDTH-1:0]            o_pkt_data,
  output logic                             o_pkt_sop,
  output logic                             o_pkt_eop,
  output logic [OFF_W-1:0]                 o_pkt_empty,
  output logic [15:0]                      o_err_cnt
);

  localparam int CNT_W = (HEAD_SLICES > 1) ? $clog2(HEAD_SLICES) : 1;
  localparam logic [OFF_W-1:0] OFF_FULL = OFF_W'(DATA_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(HEAD_SLICES - 1);

  typedef enum logic [1:0] {IDLE, HEAD, DRAIN, DROP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] slice_cnt, slice_cnt_nxt;
  logic [15:0]      seq_id;
  logic             xfer, fwd, err_inc, meta_vld;
  logic             head_vld, head_shift, head_tail, head_start;
  logic [OFF_W-1:0] head_off, beat_off;

  // o_ready is forced low while reset is held, even though o_pkt_valid is already 0
  assign o_ready  = !i_rst && (!o_pkt_valid || i_pkt_ready);
  assign xfer     = i_valid && o_ready;
  assign beat_off = i_eop ? OFF_FULL - i_empty : OFF_FULL;

  always_comb begin
    state_nxt     = state;
    slice_cnt_nxt = slice_cnt;
    fwd           = 1'b0;
    err_inc       = 1'b0;
    meta_vld      = 1'b0;
    head_vld      = 1'b0;
    head_shift    = 1'b0;
    head_tail     = 1'b0;
    head_start    = 1'b0;
    head_off      = '0;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (i_sop) begin
            fwd           = 1'b1;
            meta_vld      = 1'b1;
            head_vld      = 1'b1;
            head_shift    = 1'b1;
            head_start    = 1'b1;
            head_off      = beat_off;
            head_tail     = i_eop || (HEAD_SLICES == 1);
            slice_cnt_nxt = CNT_W'(1);
            if (i_eop)                  state_nxt = IDLE;
            else if (HEAD_SLICES == 1)  state_nxt = DRAIN;
            else                        state_nxt = HEAD;
          end else begin
            err_inc = 1'b1;
          end
        end
        HEAD: begin
          if (i_sop) begin
            // abort slice closes the open head; shift=0 and data=0 mark it as carrying no bytes
            err_inc   = 1'b1;
            head_vld  = 1'b1;
            head_tail = 1'b1;
            state_nxt = i_eop ? IDLE : DROP;
          end else begin
            fwd           = 1'b1;
            head_vld      = 1'b1;
            head_shift    = 1'b1;
            head_off      = beat_off;
            head_tail     = (slice_cnt == LAST_SLICE) || i_eop;
            slice_cnt_nxt = slice_cnt + CNT_W'(1);
            if (i_eop)                         state_nxt = IDLE;
            else if (slice_cnt == LAST_SLICE)  state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (i_sop) begin
            err_inc   = 1'b1;
            state_nxt = i_eop ? IDLE : DROP;
          end else begin
            fwd = 1'b1;
            if (i_eop) state_nxt = IDLE;
          end
        end
        DROP: begin
          if (i_sop) err_inc = 1'b1;
          if (i_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      slice_cnt <= '0;
      seq_id    <= '0;
      o_err_cnt <= '0;
      o_head    <= '0;
      o_meta    <= '0;
    end else begin
      state     <= state_nxt;
      slice_cnt <= slice_cnt_nxt;
      if (meta_vld) seq_id <= seq_id + 16'd1;
      if (err_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      o_head <= head_vld ? {(head_shift ? i_data : {DATA_WIDTH{1'b0}}),
                            head_vld, head_shift, head_tail, head_start, head_off} : '0;
      o_meta <= meta_vld ? {seq_id, i_pkt_len, i_port, {(META_WIDTH-40){1'b0}},
                            1'b1, 1'b0, 1'b1, 1'b1, {OFF_W{1'b0}}} : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pkt_valid <= 1'b0;
      o_pkt_data  <= '0;
      o_pkt_sop   <= 1'b0;
      o_pkt_eop   <= 1'b0;
      o_pkt_empty <= '0;
    end else if (xfer) begin
      // a consumed-but-dropped beat still frees the register, since o_ready implied it drained
      o_pkt_valid <= fwd;
      if (fwd) begin
        o_pkt_data  <= i_data;
        o_pkt_sop   <= i_sop;
        o_pkt_eop   <= i_eop;
        o_pkt_empty <= i_empty;
      end
    end else if (i_pkt_ready) begin
      o_pkt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parser_head_gen.sv
// Self-checking bench for parser_head_gen: directed scenarios with literal expectations,
// randomized traffic checked every cycle against a packet-level reference model.
module tb_parser_head_gen;
  localparam int DW = 256, HS = 4, MW = 128, OW = 5, TW = OW + 4;

  logic            i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic [OW-1:0]   i_empty = '0;
  logic [7:0]      i_port = '0;
  logic [15:0]     i_pkt_len = '0;
  logic            i_pkt_ready = 1'b1;
  logic            o_ready, o_pkt_valid, o_pkt_sop, o_pkt_eop;
  logic [DW+TW-1:0] o_head;
  logic [MW+TW-1:0] o_meta;
  logic [DW-1:0]   o_pkt_data;
  logic [OW-1:0]   o_pkt_empty;
  logic [15:0]     o_err_cnt;

  parser_head_gen #(.DATA_WIDTH(DW), .HEAD_SLICES(HS), .META_WIDTH(MW), .OFF_W(OW), .TAG_WIDTH(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_sop(i_sop), .i_eop(i_eop), .i_empty(i_empty), .i_port(i_port), .i_pkt_len(i_pkt_len),
    .o_head(o_head), .o_meta(o_meta), .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready),
    .o_pkt_data(o_pkt_data), .o_pkt_sop(o_pkt_sop), .o_pkt_eop(o_pkt_eop),
    .o_pkt_empty(o_pkt_empty), .o_err_cnt(o_err_cnt));

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;

  function automatic void chk(string name, logic [299:0] act, logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [TW-1:0] mk_tag(logic v, logic sh, logic tl, logic st, logic [OW-1:0] off);
    return {v, sh, tl, st, off};
  endfunction

  // Reference model: packet position, drop flag, counters, and the expected registered outputs
  int             m_pos = -1;
  bit             m_drop = 0;
  logic [15:0]    m_seq = '0, m_err = '0;
  logic [DW+TW-1:0] e_head = '0;
  logic [MW+TW-1:0] e_meta = '0;
  bit             e_pv = 0, e_ps = 0, e_pe = 0;
  logic [DW-1:0]  e_pd = '0;
  logic [OW-1:0]  e_pm = '0, m_off;
  bit             m_xfer, m_fwd;

  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("rst_ready", o_ready, 0);
      chk("rst_head", o_head, 0);
      chk("rst_meta", o_meta, 0);
      chk("rst_pkt_valid", o_pkt_valid, 0);
      chk("rst_err", o_err_cnt, 0);
      m_pos = -1; m_drop = 0; m_seq = '0; m_err = '0;
      e_head = '0; e_meta = '0; e_pv = 0;
    end else begin
      chk("m_head", o_head, e_head);
      chk("m_meta", o_meta, e_meta);
      chk("m_pkt_valid", o_pkt_valid, e_pv);
      chk("m_err", o_err_cnt, m_err);
      chk("m_ready", o_ready, !e_pv || i_pkt_ready);
      if (e_pv) begin
        chk("m_pkt_data", o_pkt_data, e_pd);
        chk("m_pkt_sop", o_pkt_sop, e_ps);
        chk("m_pkt_eop", o_pkt_eop, e_pe);
        chk("m_pkt_empty", o_pkt_empty, e_pm);
      end
      m_xfer = i_valid && (!e_pv || i_pkt_ready);
      m_fwd = 0;
      e_head = '0;
      e_meta = '0;
      m_off = i_eop ? OW'(DW / 8 - 1 - int'(i_empty)) : OW'(DW / 8 - 1);
      if (m_xfer) begin
        if (m_drop) begin
          if (i_sop && m_err != 16'hFFFF) m_err++;
          if (i_eop) m_drop = 0;
        end else if (m_pos < 0) begin
          if (i_sop) begin
            m_fwd = 1;
            e_head = {i_data, mk_tag(1, 1, i_eop || HS == 1, 1, m_off)};
            e_meta = {m_seq, i_pkt_len, i_port, 88'b0, mk_tag(1, 0, 1, 1, '0)};
            m_seq++;
            m_pos = i_eop ? -1 : 1;
          end else if (m_err != 16'hFFFF) m_err++;
        end else if (i_sop) begin
          if (m_err != 16'hFFFF) m_err++;
          if (m_pos < HS) e_head = {{DW{1'b0}}, mk_tag(1, 0, 1, 0, '0)};
          m_drop = !i_eop;
          m_pos = -1;
        end else begin
          m_fwd = 1;
          if (m_pos < HS) e_head = {i_data, mk_tag(1, 1, m_pos == HS - 1 || i_eop, 0, m_off)};
          m_pos = i_eop ? -1 : m_pos + 1;
        end
        e_pv = m_fwd;
        if (m_fwd) begin
          e_pd = i_data; e_ps = i_sop; e_pe = i_eop; e_pm = i_empty;
        end
      end else if (i_pkt_ready) e_pv = 0;
    end
  end

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_pkt_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns 1 time unit after the transfer edge
  task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                      input logic [OW-1:0] emp, input logic [7:0] port, input logic [15:0] len);
    int n;
    i_valid = 1'b1; i_data = d; i_sop = sop; i_eop = eop;
    i_empty = emp; i_port = port; i_pkt_len = len;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("beat_accept", o_ready, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      i_valid     = $urandom_range(0, 99) < 70;
      i_sop       = $urandom_range(0, 99) < 30;
      i_eop       = $urandom_range(0, 99) < 35;
      i_empty     = OW'($urandom);
      i_port      = 8'($urandom);
      i_pkt_len   = 16'($urandom);
      i_pkt_ready = $urandom_range(0, 99) < 75;
      for (int k = 0; k < DW / 32; k++) i_data[k*32 +: 32] = $urandom;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_pkt_ready = 1'b1;
  endtask

  logic [DW-1:0] d0, d1, d2;

  initial begin
    d0 = {8{32'h1111_0000}}; d1 = {8{32'h2222_0001}}; d2 = {8{32'h3333_0002}};
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // 3-beat packet: port 5, len 90, empty 6
    beat(d0, 1, 0, 0, 8'd5, 16'd90);
    chk("p3_tag0", o_head[TW-1:0], 9'h1BF);
    chk("p3_data0", o_head[DW+TW-1:TW], d0);
    chk("p3_meta_tag", o_meta[TW-1:0], 9'h160);
    chk("p3_meta_hdr", o_meta[MW+TW-1:MW+TW-40], {16'h0000, 16'h005A, 8'h05});
    chk("p3_pkt0", o_pkt_data, d0);
    beat(d1, 0, 0, 0, 8'd5, 16'd90);
    chk("p3_tag1", o_head[TW-1:0], 9'h19F);
    chk("p3_meta_idle", o_meta[TW-1:0], 0);
    beat(d2, 0, 1, 5'd6, 8'd5, 16'd90);
    chk("p3_tag2", o_head[TW-1:0], 9'h1D9);
    chk("p3_pkt_eop", {o_pkt_valid, o_pkt_eop, o_pkt_empty}, {1'b1, 1'b1, 5'd6});

    // 7-beat packet: only four head slices
    for (int i = 0; i < 7; i++) begin
      beat({8{32'(i)}}, i == 0, i == 6, 5'd3, 8'd9, 16'd200);
      chk("p7_tag", o_head[TW-1:0], i == 0 ? 9'h1BF : i < 3 ? 9'h19F : i == 3 ? 9'h1DF : 9'h000);
      chk("p7_pkt_valid", o_pkt_valid, 1);
    end
    chk("p7_meta_seq", m_seq, 16'd2);

    // single-beat packet then back-to-back SOP
    do_reset();
    beat(d0, 1, 1, 0, 8'd1, 16'd32);
    chk("sb_tag", o_head[TW-1:0], 9'h1FF);
    chk("sb_seq0", o_meta[MW+TW-1:MW+TW-16], 16'd0);
    beat(d1, 1, 1, 0, 8'd2, 16'd32);
    chk("sb_seq1", o_meta[MW+TW-1:MW+TW-16], 16'd1);
    chk("sb_err", o_err_cnt, 0);

    // payload backpressure
    do_reset();
    i_pkt_ready = 1'b0;
    beat(d0, 1, 0, 0, 8'd3, 16'd64);
    chk("bp_ready0", o_ready, 0);
    @(posedge i_clk);
    repeat (5) begin
      @(negedge i_clk);
      chk("bp_ready", o_ready, 0);
      chk("bp_head", o_head[TW-1:0], 0);
      chk("bp_meta", o_meta[TW-1:0], 0);
    end
    @(posedge i_clk); #1;
    i_pkt_ready = 1'b1;
    #1 chk("bp_ready_rise", o_ready, 1);
    beat(d1, 0, 1, 0, 8'd3, 16'd64);

    // SOP inside an open head: abort, drop, then a clean packet
    do_reset();
    beat(d0, 1, 0, 0, 8'd4, 16'd100);
    beat(d1, 0, 0, 0, 8'd4, 16'd100);
    beat(d2, 1, 0, 0, 8'd7, 16'd100);
    chk("ab_tag", o_head[TW-1:0], 9'h140);
    chk("ab_data", o_head[DW+TW-1:TW], 0);
    chk("ab_err", o_err_cnt, 1);
    chk("ab_meta", o_meta[TW-1:0], 0);
    chk("ab_pkt", o_pkt_valid, 0);
    beat(d0, 0, 0, 0, 8'd7, 16'd100);
    beat(d1, 0, 1, 0, 8'd7, 16'd100);
    chk("ab_drop_pkt", o_pkt_valid, 0);
    chk("ab_drop_head", o_head[TW-1:0], 0);
    beat(d2, 1, 0, 0, 8'd8, 16'd50);
    chk("ab_next_seq", o_meta[MW+TW-1:MW+TW-16], 16'd1);
    chk("ab_next_tag", o_head[TW-1:0], 9'h1BF);
    beat(d0, 0, 1, 0, 8'd8, 16'd50);

    // non-SOP beat while idle
    do_reset();
    beat(d0, 0, 0, 0, 8'd1, 16'd1);
    chk("ns_err", o_err_cnt, 1);
    chk("ns_head", o_head, 0);
    chk("ns_meta", o_meta, 0);
    chk("ns_pkt", o_pkt_valid, 0);

    // randomized traffic with a mid-stream reset
    rand_phase(1500);
    do_reset();
    rand_phase(1500);

    // sequence id wrap
    do_reset();
    for (int i = 0; i < 65536; i++) beat(d0, 1, 1, 0, 8'd0, 16'd32);
    chk("wrap_ffff", o_meta[MW+TW-1:MW+TW-16], 16'hFFFF);
    beat(d1, 1, 1, 0, 8'd0, 16'd32);
    chk("wrap_zero", o_meta[MW+TW-1:MW+TW-16], 16'h0000);

    @(posedge i_clk);
    @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
